// File: rtl/stage_one_fetch.sv
// stage_one_fetch
//   Instruction-fetch stage. Holds the PC, fetches one word at a time from
//   instruction memory over a req/ready handshake, presents it to decode and
//   computes the next PC from decode's controls. Also owns the hardware
//   return-address stack used by call (push) and return (pop).
//
//   FSM: FETCH (issue req) -> WAIT (hold req until imem_ready)
//        -> HOLD (present instruction until pc_write) -> FETCH
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   pc_write            decode commits the presented instruction
//   pc_src[2:0]         next-PC select
//   jump_target[25:0]   J-type target field
//   alu_out[31:0]       register-indirect target
//   push, pop           return-address stack call / return
//   imem_req/addr       fetch request and byte address (== pc)
//   imem_ready/rdata    memory response
//   instruction, pc_out registered instruction word and its PC
//   instr_valid         instruction/pc_out valid (HOLD)
//   stack_full/empty    registered stack occupancy flags
//   stack_err           (only with STACK_ERR_EN) sticky overflow/underflow flag
//
// Build option: define STACK_ERR_EN to add the stack_err output.

module stage_one_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          STACK_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic [2:0]  pc_src,
  input  logic [25:0] jump_target,
  input  logic [31:0] alu_out,
  input  logic        push,
  input  logic        pop,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic        stack_full,
  output logic        stack_empty
`ifdef STACK_ERR_EN
  ,
  output logic        stack_err
`endif
);

  localparam int IW  = $clog2(STACK_DEPTH);
  localparam int SPW = IW + 1;

  typedef enum logic [1:0] {FETCH = 2'd0, WAIT = 2'd1, HOLD = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc;
  logic [31:0]     pc4;
  logic [31:0]     next_pc;
  logic [31:0]     stack [STACK_DEPTH];
  logic [SPW-1:0]  sp, sp_d;
  logic [IW-1:0]   top_idx;
  logic [IW-1:0]   stk_widx;
  logic            stk_we;
  logic            err_ev;
  logic            commit;
  logic [31:0]     br_off;

  // The full word of alu_out is a port, but targets are word aligned.
  logic unused_alu_lsb;
  assign unused_alu_lsb = &{1'b0, alu_out[1:0]};

  assign commit   = (state_q == HOLD) && pc_write;
  assign pc4      = pc + 32'd4;
  assign top_idx  = IW'(sp - SPW'(1));
  assign br_off   = {{14{instruction[15]}}, instruction[15:0], 2'b00};

  // Request is gated with reset so it drops the instant reset asserts,
  // abandoning any outstanding fetch; the state register itself resets
  // to FETCH so the first request goes out right after release.
  assign imem_req  = rst && (state_q != HOLD);
  assign imem_addr = pc;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = WAIT;
      WAIT:    if (imem_ready) state_d = HOLD;
      HOLD:    if (pc_write)   state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // ---------------- next PC ----------------
  always_comb begin
    next_pc = pc4;
    case (pc_src)
      3'b001:  next_pc = pc4 + br_off;
      3'b010:  next_pc = {pc4[31:28], jump_target, 2'b00};
      3'b011:  next_pc = stack_empty ? pc4 : stack[top_idx];
      3'b100:  next_pc = {alu_out[31:2], 2'b00};
      default: next_pc = pc4;
    endcase
  end

  // ---------------- stack control ----------------
  // push&pop together is a tail call: the top entry is replaced in place.
  // On an empty stack there is nothing to replace, so it degrades to a
  // plain push and the pop half counts as an underflow.
  always_comb begin
    sp_d     = sp;
    stk_we   = 1'b0;
    stk_widx = sp[IW-1:0];
    err_ev   = 1'b0;
    if (commit) begin
      if (push && pop && !stack_empty) begin
        stk_we   = 1'b1;
        stk_widx = top_idx;
      end else if (push) begin
        if (!stack_full) begin
          stk_we = 1'b1;
          sp_d   = sp + SPW'(1);
        end
        err_ev = stack_full || pop;
      end else if (pop) begin
        if (!stack_empty) sp_d = sp - SPW'(1);
        else              err_ev = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (stk_we) stack[stk_widx] <= pc4;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= {RESET_PC[31:2], 2'b00};
      pc_out      <= {RESET_PC[31:2], 2'b00};
      instruction <= '0;
      instr_valid <= 1'b0;
      sp          <= '0;
      stack_full  <= 1'b0;
      stack_empty <= 1'b1;
    end else begin
      if (state_q == WAIT && imem_ready) begin
        instruction <= imem_rdata;
        pc_out      <= pc;
        instr_valid <= 1'b1;
      end
      if (commit) begin
        pc          <= next_pc;
        instr_valid <= 1'b0;
        sp          <= sp_d;
        stack_full  <= (sp_d == SPW'(STACK_DEPTH));
        stack_empty <= (sp_d == '0);
      end
    end
  end

`ifdef STACK_ERR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        stack_err <= 1'b0;
    else if (err_ev) stack_err <= 1'b1;
  end
`else
  logic unused_err_ev;
  assign unused_err_ev = err_ev;
`endif

endmodule
